mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multicycle signed multiply/divide unit that owns the HI and LO architectural registers for MULT and DIV.
- Its hi and lo outputs drive the HI and LO inputs of the write-back data-source selector, which feeds the register bank for MFHI and MFLO.
- Started by a one-cycle pulse from the control FSM. Performs one iteration per clock, then signals completion so control can leave its wait state.

Parameters:
- DATA_W, 32: operand width and width of each of HI and LO.
- ITERS, 32: number of iteration cycles. Must equal DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- mult_start  input  1  one-cycle pulse: begin signed a*b.
- div_start  input  1  one-cycle pulse: begin signed a/b.
- a  input  DATA_W  operand A (rs). Sampled only on the accepting edge.
- b  input  DATA_W  operand B (rt). Sampled only on the accepting edge.
- hi  output  DATA_W  HI register: upper product word, or remainder.
- lo  output  DATA_W  LO register: lower product word, or quotient.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.
- div_zero  output  1  one-cycle pulse when DIV is requested with b == 0.

Behaviour:
- Reset (asynchronous, at any time, including mid-operation):
  - state = IDLE; hi = 0, lo = 0; busy = 0, done = 0, div_zero = 0; iteration counter = 0.
  - The operation in progress is abandoned.
- States:
  - IDLE: waiting for a start pulse.
  - MULT: Booth iterations.
  - DIV: restoring-division iterations.
  - FINISH: write HI/LO.
  - DZERO: divide-by-zero exit.
- IDLE, on the accepting edge E0:
  - If mult_start: capture a and b, go to MULT. mult_start has priority if both starts are high.
  - Else if div_start and b == 0: go to DZERO.
  - Else if div_start: capture |a| and |b| and their signs, go to DIV.
  - busy goes high from E0.
- Start pulses received while busy are ignored and never queued.
- MULT (radix-2 Booth, signed):
  - Working register is {acc[DATA_W], q[DATA_W], q_m1} = {0, A, 0}.
  - Per cycle: q0,q_m1 = 10 means acc -= M; 01 means acc += M; 00 and 11 leave acc unchanged.
  - Then arithmetic-shift the whole register right by 1.
  - Result is the full 2*DATA_W signed product. No overflow is possible.
- DIV (restoring, on magnitudes, unsigned DATA_W+1-bit remainder):
  - Per cycle: shift {rem, quo} left by 1, trial-subtract |b| from rem. If non-negative, keep the difference and set quo[0] = 1; otherwise restore and set quo[0] = 0.
  - Final sign fix: quotient is negated if sign(a) XOR sign(b). Remainder takes the sign of a (truncation toward zero, MIPS semantics).
  - -2^31 / -1 yields lo = 0x80000000, hi = 0 (natural wraparound, no trap).
- Counter: counts iteration cycles on edges E1..E32. After the ITERS-th iteration, go to FINISH.
- FINISH, at edge E33:
  - MULT: hi = acc, lo = q.
  - DIV: hi = signed remainder, lo = signed quotient.
  - done = 1 and busy = 0 from E33 for exactly one cycle, then IDLE.
  - Total: done is visible 33 cycles after the start edge.
- DZERO, at edge E1:
  - done = 1 and div_zero = 1 for one cycle; busy = 0; hi and lo unchanged; then IDLE.
- hi and lo change only at FINISH or reset. They are never modified mid-operation, so MFHI/MFLO during busy return the previous result.
- A new start may be accepted on the same edge at which done deasserts (back-to-back operation).

Decomposition:
- Shared include/package:
  - state encodings IDLE, MULT, DIV, FINISH, DZERO;
  - DATA_W and ITERS localparams;
  - counter width = clog2(ITERS) + 1.
- One natural sub-module: div_restoring_core. It holds the remainder/quotient datapath, the per-iteration step and the final sign correction.
- The Booth datapath and the FSM stay in the top module.

Test Plan:
- mult_start, a = 7, b = 0xFFFFFFFD (-3) -> done 33 cycles after start; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; busy high throughout.
- mult_start, a = b = 0x80000000 -> hi = 0x40000000, lo = 0x00000000.
- div_start, a = 0xFFFFFFF9 (-7), b = 2 -> lo = 0xFFFFFFFD (-3), hi = 0xFFFFFFFF (-1). Then a = 0x80000000, b = 0xFFFFFFFF -> lo = 0x80000000, hi = 0.
- Preload hi/lo via a MULT; then div_start with b = 0 -> done and div_zero both high for one cycle, one cycle after start; hi and lo unchanged.
- mult_start and div_start together with a = 5, b = 3 -> multiply performed (hi = 0, lo = 15). A second start pulse at cycle 10 -> ignored, done still at cycle 33.
- Assert reset at iteration 10 of a DIV -> hi = lo = 0, busy = done = 0 immediately. A fresh mult after reset completes normally.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg
//   Shared definitions for the multiply/divide unit: default operand width,
//   iteration count, iteration-counter width and the FSM state encoding.
package mult_div_unit_pkg;

  localparam int DATA_W = 32;
  localparam int ITERS  = 32;

  // One extra bit so the counter can represent ITERS itself.
  function automatic int cnt_width(input int iters);
    return $clog2(iters) + 1;
  endfunction

  localparam int CNT_W = cnt_width(ITERS);

  typedef enum logic [2:0] {
    IDLE,
    MULT,
    DIV,
    FINISH,
    DZERO
  } state_t;

endpackage

// File: rtl/mult_div_unit_div.sv
// div_restoring_core
//   Signed divider datapath: restoring division on operand magnitudes,
//   one quotient bit per step, with sign correction applied on the outputs
//   (quotient truncates toward zero, remainder takes the dividend's sign).
// Ports:
//   clk        rising-edge clock
//   load       capture |a|, |b| and the operand signs, clear the remainder
//   step       perform one shift/trial-subtract iteration
//   a, b       dividend and divisor (two's complement)
//   quotient   sign-corrected quotient
//   remainder  sign-corrected remainder
module div_restoring_core #(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     load,
  input  logic                     step,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] quotient,
  output logic signed [DATA_W-1:0] remainder
);
  import mult_div_unit_pkg::*;

  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W-1:0] dvs;
  logic              neg_q;
  logic              neg_r;
  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] diff;
  logic              fits;

  // Magnitude as an unsigned value; -2^(W-1) maps to 2^(W-1), which is exact.
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] x);
    return x[DATA_W-1] ? $unsigned(-x) : $unsigned(x);
  endfunction

  // The shifted remainder is DATA_W+1 bits wide; after a successful subtract
  // the difference is below the divisor, so DATA_W bits suffice to store it.
  assign shifted = {rem, quo[DATA_W-1]};
  assign fits    = (shifted >= {1'b0, dvs});
  assign diff    = shifted[DATA_W-1:0] - dvs;

  always_ff @(posedge clk) begin
    if (load) begin
      rem   <= '0;
      quo   <= magnitude(a);
      dvs   <= magnitude(b);
      neg_q <= a[DATA_W-1] ^ b[DATA_W-1];
      neg_r <= a[DATA_W-1];
    end else if (step) begin
      rem <= fits ? diff : shifted[DATA_W-1:0];
      quo <= {quo[DATA_W-2:0], fits};
    end
  end

  // Negating a magnitude of 2^(W-1) wraps to itself, giving the
  // -2^(W-1) / -1 = -2^(W-1) result without a special case.
  assign quotient  = neg_q ? -$signed(quo) : $signed(quo);
  assign remainder = neg_r ? -$signed(rem) : $signed(rem);

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Multicycle signed multiply/divide unit owning the HI/LO registers.
//   MULT uses radix-2 Booth recoding, DIV uses the restoring core. Each
//   operation runs ITERS iteration cycles then writes HI/LO in FINISH.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   mult_start  one-cycle pulse, start signed a*b
//   div_start   one-cycle pulse, start signed a/b
//   a, b        operands, sampled only on the accepting edge
//   hi, lo      HI/LO registers (product words, or remainder/quotient)
//   busy        operation in progress
//   done        one-cycle completion pulse
//   div_zero    one-cycle pulse for a divide by zero
module mult_div_unit #(
  parameter int DATA_W = mult_div_unit_pkg::DATA_W,
  parameter int ITERS  = mult_div_unit_pkg::ITERS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mult_start,
  input  logic              div_start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  output logic              busy,
  output logic              done,
  output logic              div_zero
);
  import mult_div_unit_pkg::*;

  localparam int CW = cnt_width(ITERS);

  state_t                  state;
  logic [CW-1:0]           cnt;
  logic                    op_div;
  logic                    accept_mult;
  logic                    accept_div;
  logic                    div_step;
  logic signed [DATA_W:0]  acc;
  logic signed [DATA_W:0]  m_ext;
  logic signed [DATA_W:0]  acc_sum;
  logic [DATA_W-1:0]       q;
  logic                    q_m1;
  logic signed [DATA_W-1:0] div_quo;
  logic signed [DATA_W-1:0] div_rem;

  assign accept_mult = (state == IDLE) && mult_start;
  assign accept_div  = (state == IDLE) && !mult_start && div_start && (b != '0);
  assign div_step    = (state == DIV);

  // Control FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_div   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          cnt      <= '0;
          if (mult_start) begin
            state  <= MULT;
            op_div <= 1'b0;
            busy   <= 1'b1;
          end else if (div_start) begin
            busy   <= 1'b1;
            op_div <= 1'b1;
            state  <= (b == '0) ? DZERO : DIV;
          end
        end
        MULT, DIV: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITERS - 1)) state <= FINISH;
        end
        FINISH: begin
          hi    <= op_div ? div_rem : acc[DATA_W-1:0];
          lo    <= op_div ? div_quo : q;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        DZERO: begin
          done     <= 1'b1;
          div_zero <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Booth recoding on {q[0], q_m1}; the accumulator carries one guard bit so
  // that subtracting M = -2^(W-1) cannot overflow before the shift.
  always_comb begin
    acc_sum = acc;
    case ({q[0], q_m1})
      2'b10:   acc_sum = acc - m_ext;
      2'b01:   acc_sum = acc + m_ext;
      default: acc_sum = acc;
    endcase
  end

  // Booth datapath
  always_ff @(posedge clk) begin
    if (accept_mult) begin
      acc   <= '0;
      q     <= a;
      q_m1  <= 1'b0;
      m_ext <= {b[DATA_W-1], b};
    end else if (state == MULT) begin
      acc  <= acc_sum >>> 1;
      q    <= {acc_sum[0], q[DATA_W-1:1]};
      q_m1 <= q[0];
    end
  end

  div_restoring_core #(
    .DATA_W(DATA_W)
  ) u_div (
    .clk       (clk),
    .load      (accept_div),
    .step      (div_step),
    .a         (a),
    .b         (b),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Self-checking bench: a transaction-level reference (plain signed
//   arithmetic plus a completion countdown) is compared against the DUT on
//   every falling edge, with literal checks on the directed cases.
module tb_mult_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         mult_start = 1'b0;
  logic         div_start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         busy;
  logic         done;
  logic         div_zero;

  mult_div_unit dut (
    .clk        (clk),
    .reset      (reset),
    .mult_start (mult_start),
    .div_start  (div_start),
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference result {hi, lo} from plain signed arithmetic.
  function automatic logic [63:0] ref_result(input bit is_div, input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    longint p;
    int sx;
    int sy;
    sx = $signed(x);
    sy = $signed(y);
    if (!is_div) begin
      p = longint'(sx) * longint'(sy);
      return p;
    end
    if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    return {32'(sx % sy), 32'(sx / sy)};
  endfunction

  // Transaction-level model: an accepted operation completes a fixed number
  // of edges later; results are applied only at completion.
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic         m_dz = 1'b0;
  int           remain = 0;
  logic [63:0]  pend = '0;
  bit           pend_dz = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_dz = 1'b0; remain = 0;
    end else begin
      m_done = 1'b0;
      m_dz   = 1'b0;
      if (remain > 0) begin
        remain--;
        if (remain == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          if (pend_dz) m_dz = 1'b1;
          else {m_hi, m_lo} = pend;
        end
      end else if (mult_start) begin
        m_busy = 1'b1; pend_dz = 1'b0; remain = 33; pend = ref_result(1'b0, a, b);
      end else if (div_start) begin
        m_busy = 1'b1;
        if (b == '0) begin
          pend_dz = 1'b1; remain = 1;
        end else begin
          pend_dz = 1'b0; remain = 33; pend = ref_result(1'b1, a, b);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", W'(busy), W'(m_busy));
    chk("done", W'(done), W'(m_done));
    chk("div_zero", W'(div_zero), W'(m_dz));
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
  end

  // Called at a falling edge; the start is sampled on the next rising edge.
  task automatic start_op(input bit ms, input bit ds, input logic [W-1:0] x, input logic [W-1:0] y);
    mult_start = ms; div_start = ds; a = x; b = y;
    start_cyc = cyc + 1;
    @(negedge clk);
    mult_start = 1'b0; div_start = 1'b0; a = $urandom; b = $urandom;
  endtask

  // Waits (bounded) for done; optionally throws start pulses that must be ignored.
  task automatic wait_done(input bit noise, output int lat);
    while (!done && (cyc - start_cyc) < 100) begin
      @(negedge clk);
      if (noise) begin
        mult_start = ($urandom % 5 == 0);
        div_start  = ($urandom % 5 == 0);
        a = $urandom;
        b = $urandom % 4;
      end
    end
    mult_start = 1'b0;
    div_start  = 1'b0;
    lat = cyc - start_cyc;
  endtask

  initial begin
    int lat;
    int exp_lat;
    bit ms;
    bit ds;
    logic [W-1:0] x;
    logic [W-1:0] y;

    repeat (2) @(negedge clk);
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", W'(busy), 32'h0);
    chk("reset_done", W'(done), 32'h0);
    chk("reset_dz", W'(div_zero), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
    wait_done(1'b0, lat);
    chk("mult1_lat", lat, 33);
    chk("mult1_hi", hi, 32'hFFFF_FFFF);
    chk("mult1_lo", lo, 32'hFFFF_FFEB);

    @(negedge clk);
    start_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000);
    wait_done(1'b0, lat);
    chk("mult2_hi", hi, 32'h4000_0000);
    chk("mult2_lo", lo, 32'h0000_0000);

    // Back-to-back: accepted on the edge where done drops.
    start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(1'b0, lat);
    chk("div1_lat", lat, 33);
    chk("div1_hi", hi, 32'hFFFF_FFFF);
    chk("div1_lo", lo, 32'hFFFF_FFFD);

    start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1'b0, lat);
    chk("div2_hi", hi, 32'h0);
    chk("div2_lo", lo, 32'h8000_0000);

    start_op(1'b1, 1'b0, 32'd100000, 32'd300000);
    wait_done(1'b0, lat);
    chk("mult3_hi", hi, 32'h0000_0006);
    chk("mult3_lo", lo, 32'hFC23_AC00);

    start_op(1'b0, 1'b1, 32'd1234, 32'd0);
    wait_done(1'b0, lat);
    chk("dz_lat", lat, 1);
    chk("dz_flag", W'(div_zero), 32'h1);
    chk("dz_hi", hi, 32'h0000_0006);
    chk("dz_lo", lo, 32'hFC23_AC00);
    @(negedge clk);
    chk("dz_done_drop", W'(done), 32'h0);
    chk("dz_flag_drop", W'(div_zero), 32'h0);

    start_op(1'b1, 1'b1, 32'd5, 32'd3);
    repeat (9) @(negedge clk);
    div_start = 1'b1; a = 32'd100; b = 32'd0;
    @(negedge clk);
    div_start = 1'b0;
    wait_done(1'b0, lat);
    chk("both_lat", lat, 33);
    chk("both_hi", hi, 32'h0);
    chk("both_lo", lo, 32'd15);

    @(negedge clk);
    start_op(1'b0, 1'b1, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    chk("rst_mid_busy", W'(busy), 32'h0);
    chk("rst_mid_done", W'(done), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start_op(1'b1, 1'b0, 32'hFFFF_FFFA, 32'd7);
    wait_done(1'b0, lat);
    chk("post_rst_lat", lat, 33);
    chk("post_rst_hi", hi, 32'hFFFF_FFFF);
    chk("post_rst_lo", lo, 32'hFFFF_FFD6);

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom % 3) @(negedge clk);
      x = $urandom;
      case ($urandom % 6)
        0:       y = 32'd0;
        1:       y = $urandom % 16;
        2:       begin x = 32'h8000_0000; y = 32'hFFFF_FFFF; end
        default: y = $urandom;
      endcase
      ms = ($urandom % 2 == 0);
      ds = !ms || ($urandom % 4 == 0);
      exp_lat = (!ms && y == 32'd0) ? 1 : 33;
      start_op(ms, ds, x, y);
      wait_done(1'b1, lat);
      chk("rand_lat", lat, exp_lat);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
